// File: rtl/dual_crack_ctrl.sv
// -----------------------------------------------------------------------------
// dual_crack_ctrl
//
// Search controller sitting one level above two crack cores. Core 0 walks the
// even keys and core 1 the odd keys. One accepted request launches both cores.
// The first core to return with a valid key wins. If both cores exhaust their
// key space, the search fails. The losing core cannot be aborted, so the
// controller drains it before it accepts another request.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   en / rdy                request pulse / idle indication (registered)
//   key, key_valid, winner  result of the last search, held until next accept
//   cycles                  launch-to-result cycle count, saturating
//   cN_en                   one-cycle start pulse to core N
//   cN_rdy                  core N idle (falls while searching, rises on return)
//   cN_key, cN_key_valid    core N result, meaningful on the cN_rdy rising edge
//   dbg_state               current FSM state encoding (observability)
//
// Request handshake: a request is taken on a rising clk edge where en=1 and
// rdy=1. An en seen while rdy=0 is dropped; it is not queued. rdy is a
// registered output, so it is already 0 in the cycle after the request is
// taken. It returns to 1 only after both cores are idle again.
// -----------------------------------------------------------------------------
module dual_crack_ctrl #(
  parameter int CNT_W        = 32,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic [23:0]      key,
  output logic             key_valid,
  output logic             winner,
  output logic [CNT_W-1:0] cycles,
  output logic             c0_en,
  input  logic             c0_rdy,
  input  logic [23:0]      c0_key,
  input  logic             c0_key_valid,
  output logic             c1_en,
  input  logic             c1_rdy,
  input  logic [23:0]      c1_key,
  input  logic             c1_key_valid,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  localparam int              TO_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            c0_rdy_q, c1_rdy_q;
  logic            seen0_q, seen1_q;
  logic            done0_q, done1_q;
  logic            hit0_q, hit1_q;
  logic [TO_W-1:0] to_cnt_q;

  logic accept;
  logic rise0, rise1;
  logic hit_now0, hit_now1;
  logic eval;
  logic all_done, any_hit;
  logic finish_hit, finish_miss;
  logic busy_seen, timeout;

  // The core rdy terms in accept keep cN_en from ever pulsing at a busy core,
  // even if a core dropped rdy without being launched.
  assign accept   = (state_q == S_IDLE) & en & rdy & c0_rdy & c1_rdy;

  // A core returns on the rising edge of its rdy, seen against last cycle.
  assign rise0    = c0_rdy & ~c0_rdy_q;
  assign rise1    = c1_rdy & ~c1_rdy_q;
  assign hit_now0 = rise0 & c0_key_valid;
  assign hit_now1 = rise1 & c1_key_valid;

  // Results are evaluated in WAIT_BUSY too. Otherwise a core that finishes
  // before its partner has even gone busy would have its return missed.
  assign eval        = (state_q == S_WAIT_BUSY) | (state_q == S_RUN);
  assign all_done    = (done0_q | rise0) & (done1_q | rise1);
  assign any_hit     = hit0_q | hit1_q | hit_now0 | hit_now1;
  assign finish_hit  = eval & (hit_now0 | hit_now1);
  assign finish_miss = eval & all_done & ~any_hit;

  // Each core's falling rdy is remembered, so the two may fall on different
  // cycles.
  assign busy_seen = (seen0_q | ~c0_rdy) & (seen1_q | ~c1_rdy);
  assign timeout   = (state_q == S_WAIT_BUSY) & (to_cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (finish_hit || finish_miss) state_d = S_DRAIN;
        else if (busy_seen)            state_d = S_RUN;
        else if (timeout)              state_d = S_DRAIN;
      end
      S_RUN:       if (finish_hit || finish_miss) state_d = S_DRAIN;
      S_DRAIN:     if (c0_rdy && c1_rdy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    c0_en     = 1'b0;
    c1_en     = 1'b0;
    dbg_state = state_q;
    if (state_q == S_LAUNCH) begin
      c0_en = 1'b1;
      c1_en = 1'b1;
    end
  end

  // Datapath: result capture, flags, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy       <= 1'b1;
      key       <= '0;
      key_valid <= 1'b0;
      winner    <= 1'b0;
      cycles    <= '0;
      c0_rdy_q  <= 1'b1;
      c1_rdy_q  <= 1'b1;
      seen0_q   <= 1'b0;
      seen1_q   <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      hit0_q    <= 1'b0;
      hit1_q    <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      c0_rdy_q <= c0_rdy;
      c1_rdy_q <= c1_rdy;
      rdy      <= (state_d == S_IDLE) & c0_rdy & c1_rdy;

      if (accept) begin
        key_valid <= 1'b0;
        cycles    <= '0;
        seen0_q   <= 1'b0;
        seen1_q   <= 1'b0;
        done0_q   <= 1'b0;
        done1_q   <= 1'b0;
        hit0_q    <= 1'b0;
        hit1_q    <= 1'b0;
        to_cnt_q  <= '0;
      end

      if (state_q == S_WAIT_BUSY) begin
        seen0_q  <= seen0_q | ~c0_rdy;
        seen1_q  <= seen1_q | ~c1_rdy;
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      // key_valid was cleared on accept, so a miss or timeout leaves it 0.
      // Outside eval nothing here fires, which discards the loser's result.
      if (eval) begin
        if (cycles != '1) cycles <= cycles + CNT_W'(1);
        done0_q <= done0_q | rise0;
        done1_q <= done1_q | rise1;
        hit0_q  <= hit0_q | hit_now0;
        hit1_q  <= hit1_q | hit_now1;
        if (hit_now0) begin
          // Core 0 takes priority when both cores hit on the same cycle.
          key       <= c0_key;
          winner    <= 1'b0;
          key_valid <= 1'b1;
        end else if (hit_now1) begin
          key       <= c1_key;
          winner    <= 1'b1;
          key_valid <= 1'b1;
        end
      end
    end
  end

endmodule
